uart_rx_byte: RTL and testbench

- 8N1 UART receiver that turns the board's serial RX pin into a held command byte plus a one-cycle strobe.
- Sits directly upstream of the pattern-select decoder, which drives the WS2812 pattern mux. That decoder maps ASCII '1'/'2'/'3' (8'h31/32/33) to selects 0/1/2 and any other byte to select 3.
- Handles pin synchronisation, mid-bit sampling, glitch rejection on the start bit and framing-error detection.
- Only bytes with a valid stop bit update the held output.

---
 rtl/uart_rx_byte.sv | 129 ++++++++++++
 tb/tb_uart_rx_byte.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the RX pin, samples mid-bit, rejects start-bit
// glitches and flags framing errors; good bytes are held on o_data with a strobe.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_bit_cnt, w_bit_cnt_nx;
  logic [2:0]    r_bit_idx, w_bit_idx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [7:0]    r_data, w_data_nx;
  logic          r_valid, w_valid_nx;
  logic          r_frame_err, w_frame_err_nx;
  logic          w_rx_s;
  logic          w_cnt_last;

  assign w_rx_s     = r_sync2;
  assign w_cnt_last = (r_bit_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= i_rx;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_bit_idx   <= w_bit_idx_nx;
      r_shift     <= w_shift_nx;
      r_data      <= w_data_nx;
      r_valid     <= w_valid_nx;
      r_frame_err <= w_frame_err_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_bit_cnt_nx   = r_bit_cnt;
    w_bit_idx_nx   = r_bit_idx;
    w_shift_nx     = r_shift;
    w_data_nx      = r_data;
    w_valid_nx     = 1'b0;
    w_frame_err_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nx   = S_START;
          w_bit_cnt_nx = '0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a high here was only a glitch.
        if (r_bit_cnt == HALF_M1) begin
          w_bit_cnt_nx = '0;
          w_bit_idx_nx = '0;
          w_state_nx   = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_bit_cnt_nx = r_bit_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_shift_nx   = {w_rx_s, r_shift[7:1]};
          w_bit_cnt_nx = '0;
          w_bit_idx_nx = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
        end else begin
          w_bit_cnt_nx = r_bit_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          w_bit_cnt_nx = '0;
          if (w_rx_s) begin
            w_data_nx  = r_shift;
            w_valid_nx = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_frame_err_nx = 1'b1;
            w_state_nx     = S_WAIT_HIGH;
          end
        end else begin
          w_bit_cnt_nx = r_bit_cnt + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        // A held-low (break) line must go high before a new frame can start.
        if (w_rx_s) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // o_valid is a one-cycle strobe with no ready; o_data stays stable until the next strobe.
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: good frames, back-to-back
// frames, start glitch, framing error with break, and reset mid-frame.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard
  logic [7:0] exp_q[$];
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int last_valid_cyc = 0;
  logic busy_seen = 1'b0;

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (valid || frame_err) check("valid_ferr_excl", {31'd0, valid & frame_err}, 32'd0);
    if (frame_err) ferr_cnt++;
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  int t_start = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int v0, f0, lat;
  logic any_high;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;

    // idle line after reset
    any_high = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid || frame_err || busy) any_high = 1'b1;
    end
    check("idle_quiet", {31'd0, any_high}, 32'd0);
    check("idle_data", {24'd0, data}, 32'h00);

    // single good byte with latency check
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b1);
    idle(2 * CPB);
    check("b32_valid_cnt", valid_cnt, 1);
    check("b32_data", {24'd0, data}, 32'h32);
    check("b32_ferr_cnt", ferr_cnt, 0);
    check("b32_busy_low", {31'd0, busy}, 32'd0);
    lat = last_valid_cyc - t_start;
    check("b32_latency", {31'd0, (lat >= 153 && lat <= 157)}, 32'd1);

    // back-to-back, then bit-order pattern
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    idle(2 * CPB);
    check("b2b_valid_cnt", valid_cnt, 3);
    check("b2b_data", {24'd0, data}, 32'h33);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_valid_cnt", valid_cnt, 4);

    // 3-cycle start glitch
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_valid_cnt", valid_cnt, 4);
    check("glitch_ferr_cnt", ferr_cnt, 0);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_data", {24'd0, data}, 32'hA5);

    // framing error followed by break
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_busy_wait", {31'd0, busy}, 32'd1);
    check("ferr_valid_cnt", valid_cnt, 4);
    check("ferr_data_kept", {24'd0, data}, 32'hA5);
    idle(2 * CPB);
    check("ferr_busy_low", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    idle(2 * CPB);
    check("after_ferr_data", {24'd0, data}, 32'h31);
    check("after_ferr_valid_cnt", valid_cnt, 5);

    // reset during data bit 4 of 8'h33
    begin
      logic [9:0] frame;
      frame = {1'b1, 8'h33, 1'b0};
      for (int i = 0; i < 5; i++) drive_bit(frame[i]);
      rx = frame[5];
      repeat (CPB / 2) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_data", {24'd0, data}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(CPB);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    check("midrst_no_valid", v0, 5);
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    idle(2 * CPB);
    check("midrst_next_data", {24'd0, data}, 32'h31);
    check("midrst_one_valid", valid_cnt - v0, 1);
    check("midrst_no_ferr", ferr_cnt - f0, 0);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
